doorbell_chime_ctrl: RTL and testbench

//  Sequencer for the doorbell chime mux: drives its sel input so that one button

---
 rtl/doorbell_chime_ctrl.sv | 142 ++++++++++++++
 tb/tb_doorbell_chime_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/doorbell_chime_ctrl.sv
// Doorbell chime sequencer: one press plays DING, optional silent GAP, then DONG,
// with a one-deep press queue and a registered sound gate / mux select.
module doorbell_chime_ctrl #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DING_CYCLES = 1000,
   parameter int unsigned GAP_CYCLES  = 200,
   parameter int unsigned DONG_CYCLES = 1500
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic button,
   output logic sel,
   output logic sound_on,
   output logic busy,
   output logic done
);

   // Counter reload values are phase_len-1 so a phase of N clocks ends on the N-th edge.
   localparam logic [CNT_W-1:0] DING_LOAD = CNT_W'(DING_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] DONG_LOAD = CNT_W'(DONG_CYCLES - 1);
   localparam bit               HAS_GAP   = (GAP_CYCLES != 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DING = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONG = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pending_q, pending_d;
   logic             button_q;
   logic             done_d;
   logic             sel_q, sound_on_q, busy_q, done_q;
   logic             press;
   logic             expire;

   assign press  = button & ~button_q;
   assign expire = (cnt_q == '0);

   // Next-state, counter and queue logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = (state_q == ST_IDLE) ? cnt_q : cnt_q - CNT_W'(1);
      pending_d = pending_q;
      done_d    = 1'b0;

      if (!enable) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         pending_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (press) begin
                  state_d = ST_DING;
                  cnt_d   = DING_LOAD;
               end
            end
            ST_DING: begin
               if (press) pending_d = 1'b1;
               if (expire) begin
                  if (HAS_GAP) begin
                     state_d = ST_GAP;
                     cnt_d   = GAP_LOAD;
                  end else begin
                     state_d = ST_DONG;
                     cnt_d   = DONG_LOAD;
                  end
               end
            end
            ST_GAP: begin
               if (press) pending_d = 1'b1;
               if (expire) begin
                  state_d = ST_DONG;
                  cnt_d   = DONG_LOAD;
               end
            end
            ST_DONG: begin
               if (expire) begin
                  // A press on the expiry edge restarts directly instead of queueing.
                  done_d    = 1'b1;
                  pending_d = 1'b0;
                  if (pending_q || press) begin
                     state_d = ST_DING;
                     cnt_d   = DING_LOAD;
                  end else begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end
               end else if (press) begin
                  pending_d = 1'b1;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               pending_d = 1'b0;
            end
         endcase
      end
   end

   // State, counter and edge-detect registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         button_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         button_q  <= button;
      end
   end

   // Outputs decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q      <= 1'b0;
         sound_on_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         sel_q      <= (state_d == ST_DONG);
         sound_on_q <= (state_d == ST_DING) || (state_d == ST_DONG);
         busy_q     <= (state_d != ST_IDLE);
         done_q     <= done_d;
      end
   end

   assign sel      = sel_q;
   assign sound_on = sound_on_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_doorbell_chime_ctrl.sv
// Bench for doorbell_chime_ctrl: two instances (with and without a gap phase) checked
// every cycle against a timeline model of the chime.
module tb_doorbell_chime_ctrl;

   localparam int unsigned CW   = 4;
   localparam int unsigned DING = 4;
   localparam int unsigned GAP  = 2;
   localparam int unsigned DONG = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       button;
   logic [1:0] sel_v, son_v, busy_v, done_v;

   int n_vec = 0;
   int n_err = 0;

   // Model: chime is a timeline; elapsed counts edges since the starting press.
   bit m_active [2];
   int m_el     [2];
   bit m_pend   [2];
   bit m_prev   [2];
   bit m_done   [2];
   int gap_len  [2];

   always #5 clk = ~clk;

   doorbell_chime_ctrl #(
      .CNT_W(CW), .DING_CYCLES(DING), .GAP_CYCLES(GAP), .DONG_CYCLES(DONG)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .button(button),
      .sel(sel_v[0]), .sound_on(son_v[0]), .busy(busy_v[0]), .done(done_v[0])
   );

   doorbell_chime_ctrl #(
      .CNT_W(CW), .DING_CYCLES(DING), .GAP_CYCLES(0), .DONG_CYCLES(DONG)
   ) u_dut_nogap (
      .clk(clk), .rst_n(rst_n), .enable(enable), .button(button),
      .sel(sel_v[1]), .sound_on(son_v[1]), .busy(busy_v[1]), .done(done_v[1])
   );

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_active[m] = 1'b0;
         m_el[m]     = 0;
         m_pend[m]   = 1'b0;
         m_prev[m]   = 1'b0;
         m_done[m]   = 1'b0;
      end
   endtask

   task automatic model_step(input bit en, input bit btn);
      bit press;
      int total;
      for (int m = 0; m < 2; m++) begin
         press     = btn && !m_prev[m];
         m_prev[m] = btn;
         total     = int'(DING + DONG) + gap_len[m];
         m_done[m] = 1'b0;
         if (!en) begin
            m_active[m] = 1'b0;
            m_pend[m]   = 1'b0;
         end else if (m_active[m]) begin
            m_el[m] = m_el[m] + 1;
            if (m_el[m] == total) begin
               m_done[m] = 1'b1;
               if (m_pend[m] || press) m_el[m] = 0;
               else                    m_active[m] = 1'b0;
               m_pend[m] = 1'b0;
            end else if (press) begin
               m_pend[m] = 1'b1;
            end
         end else if (press) begin
            m_active[m] = 1'b1;
            m_el[m]     = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic obs, input bit exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%0b at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string step);
      bit in_dong, snd;
      for (int m = 0; m < 2; m++) begin
         in_dong = m_active[m] && (m_el[m] >= int'(DING) + gap_len[m]);
         snd     = m_active[m] && ((m_el[m] < int'(DING)) || in_dong);
         chk($sformatf("%s.dut%0d.sel", step, m),      sel_v[m],  in_dong);
         chk($sformatf("%s.dut%0d.sound_on", step, m), son_v[m],  snd);
         chk($sformatf("%s.dut%0d.busy", step, m),     busy_v[m], m_active[m]);
         chk($sformatf("%s.dut%0d.done", step, m),     done_v[m], m_done[m]);
      end
   endtask

   task automatic cycle(input string step, input bit en, input bit btn);
      enable = en;
      button = btn;
      @(posedge clk);
      model_step(en, btn);
      #1;
      check_all(step);
   endtask

   task automatic idle_cycles(input string step, input int n);
      for (int i = 0; i < n; i++) cycle(step, 1'b1, 1'b0);
   endtask

   initial begin
      bit en, b;
      gap_len[0] = int'(GAP);
      gap_len[1] = 0;
      rst_n  = 1'b0;
      enable = 1'b0;
      button = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycles("post_reset", 3);

      // Single press, then idle long enough for both chimes to finish.
      cycle("single", 1'b1, 1'b1);
      idle_cycles("single", 12);

      // Held button: edge detect yields one chime only.
      for (int i = 0; i < 20; i++) cycle("held", 1'b1, 1'b1);
      idle_cycles("held", 6);

      // Press, queue a press in GAP, then an extra press in DONG that is dropped.
      cycle("queue", 1'b1, 1'b1);
      idle_cycles("queue", 3);
      cycle("queue", 1'b1, 1'b1);
      cycle("queue", 1'b1, 1'b0);
      cycle("queue", 1'b1, 1'b0);
      cycle("queue", 1'b1, 1'b1);
      idle_cycles("queue", 24);

      // Abort during DING with a queued press; pending must be lost.
      cycle("abort", 1'b1, 1'b1);
      cycle("abort", 1'b1, 1'b0);
      cycle("abort", 1'b1, 1'b1);
      cycle("abort", 1'b0, 1'b0);
      idle_cycles("abort", 12);
      cycle("fresh", 1'b1, 1'b1);
      idle_cycles("fresh", 12);

      // Async reset in the middle of DONG.
      cycle("rst_mid", 1'b1, 1'b1);
      idle_cycles("rst_mid", 7);
      button = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycles("rst_release", 4);

      // Random enable/button traffic.
      b = 1'b0;
      for (int i = 0; i < 600; i++) begin
         en = ($urandom_range(0, 24) != 0);
         if ($urandom_range(0, 3) == 0) b = ~b;
         cycle("random", en, b);
      end
      idle_cycles("drain", 15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
